imem_loadable: RTL and testbench

- Parametrised successor to the fixed combinational instruction ROM.
- Holds the CPU program in a writable array that is filled through a streaming load port after reset.
- Serves instruction fetches with a registered, one-cycle read, with stall, flush and out-of-range handling.
- Sits between the PC/fetch stage and the decode stage; the loader (testbench or boot unit) drives the load port.

---
 rtl/imem_loadable_pkg.sv | 18 +
 rtl/imem_array.sv | 29 ++
 rtl/imem_loadable.sv | 136 +++++++++++++
 tb/tb_imem_loadable.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: default word format,
// LOAD/RUN state encoding and the load-counter width helper.
package imem_loadable_pkg;

   localparam int INST_WIDTH_DEF = 16;
   localparam logic [INST_WIDTH_DEF-1:0] NOP_INST_DEF = '0;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } imem_state_t;

   // The counter must be able to represent DEPTH itself, since that value means "array full".
   function automatic int load_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x INST_WIDTH instruction storage with one synchronous write port and one
// synchronous read port; contents are deliberately left unreset.
module imem_array #(
   parameter int DEPTH      = 64,
   parameter int INST_WIDTH = 16,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [INST_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [INST_WIDTH-1:0] rd_data
);

   logic [INST_WIDTH-1:0] mem [DEPTH];

   // The read data register only updates on an enabled read, so it doubles as the held fetch value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: streams a program in after reset, then serves
// registered one-cycle fetches with stall, flush and out-of-range handling.
module imem_loadable
   import imem_loadable_pkg::*;
#(
   parameter int                    INST_WIDTH = INST_WIDTH_DEF,
   parameter int                    DEPTH      = 64,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(NOP_INST_DEF)
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic                               load_valid_i,
   input  logic [INST_WIDTH-1:0]              load_data_i,
   input  logic                               load_last_i,
   output logic                               load_ready_o,
   output logic [load_cnt_width(DEPTH)-1:0]   load_count_o,
   output logic                               load_ovf_o,
   input  logic                               reload_i,
   output logic                               run_o,
   input  logic                               fetch_req_i,
   input  logic [ADDR_WIDTH-1:0]              PC_i,
   input  logic                               stall_i,
   input  logic                               flush_i,
   output logic [INST_WIDTH-1:0]              inst_o,
   output logic                               inst_valid_o,
   output logic                               addr_err_o
);

   localparam int CW = load_cnt_width(DEPTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   DEPTH_PC  = (ADDR_WIDTH + 1)'(DEPTH);

   imem_state_t           state;
   logic [CW-1:0]         load_count;
   logic                  load_ovf;
   logic                  inst_valid;
   logic                  addr_err;
   logic                  nop_sel;
   logic                  full;
   logic                  pc_in_range;
   logic                  wr_en;
   logic                  rd_en;
   logic [INST_WIDTH-1:0] rd_data;

   assign full        = (load_count == DEPTH_CNT);
   assign pc_in_range = ({1'b0, PC_i} < DEPTH_PC);

   assign wr_en = (state == ST_LOAD) && load_valid_i && !full;
   assign rd_en = (state == ST_RUN) && !reload_i && !flush_i && !stall_i
                  && fetch_req_i && pc_in_range;

   imem_array #(
      .DEPTH      (DEPTH),
      .INST_WIDTH (INST_WIDTH),
      .ADDR_W     (AW)
   ) u_array (
      .clk     (clk_i),
      .wr_en   (wr_en),
      .wr_addr (load_count[AW-1:0]),
      .wr_data (load_data_i),
      .rd_en   (rd_en),
      .rd_addr (PC_i[AW-1:0]),
      .rd_data (rd_data)
   );

   // nop_sel is the reset-able half of the output register; the unreset read data
   // register supplies the instruction only when nop_sel is clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_LOAD;
         load_count <= '0;
         load_ovf   <= 1'b0;
         inst_valid <= 1'b0;
         addr_err   <= 1'b0;
         nop_sel    <= 1'b1;
      end else begin
         case (state)
            ST_LOAD: begin
               inst_valid <= 1'b0;
               addr_err   <= 1'b0;
               nop_sel    <= 1'b1;
               if (load_valid_i) begin
                  if (full) begin
                     load_ovf <= 1'b1;
                  end else begin
                     load_count <= load_count + 1'b1;
                  end
                  if (load_last_i) begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (reload_i) begin
                  state      <= ST_LOAD;
                  load_count <= '0;
                  load_ovf   <= 1'b0;
                  inst_valid <= 1'b0;
                  addr_err   <= 1'b0;
                  nop_sel    <= 1'b1;
               end else if (flush_i) begin
                  inst_valid <= 1'b0;
                  addr_err   <= 1'b0;
                  nop_sel    <= 1'b1;
               end else if (stall_i) begin
                  inst_valid <= inst_valid;
                  addr_err   <= addr_err;
                  nop_sel    <= nop_sel;
               end else if (fetch_req_i) begin
                  inst_valid <= 1'b1;
                  addr_err   <= !pc_in_range;
                  nop_sel    <= !pc_in_range;
               end else begin
                  inst_valid <= 1'b0;
                  addr_err   <= 1'b0;
                  nop_sel    <= 1'b1;
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   assign load_ready_o = (state == ST_LOAD);
   assign run_o        = (state == ST_RUN);
   assign load_count_o = load_count;
   assign load_ovf_o   = load_ovf;
   assign inst_o       = nop_sel ? NOP_INST : rd_data;
   assign inst_valid_o = inst_valid;
   assign addr_err_o   = addr_err;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable: load, fetch, stall/flush,
// out-of-range, overflow, reload and asynchronous reset.
module tb_imem_loadable;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        load_valid_i;
   logic [15:0] load_data_i;
   logic        load_last_i;
   logic        load_ready_o;
   logic [6:0]  load_count_o;
   logic        load_ovf_o;
   logic        reload_i;
   logic        run_o;
   logic        fetch_req_i;
   logic [15:0] PC_i;
   logic        stall_i;
   logic        flush_i;
   logic [15:0] inst_o;
   logic        inst_valid_o;
   logic        addr_err_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] prog [5];

   imem_loadable #(
      .INST_WIDTH (16),
      .DEPTH      (64),
      .ADDR_WIDTH (16),
      .NOP_INST   (16'h0000)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .load_valid_i (load_valid_i),
      .load_data_i  (load_data_i),
      .load_last_i  (load_last_i),
      .load_ready_o (load_ready_o),
      .load_count_o (load_count_o),
      .load_ovf_o   (load_ovf_o),
      .reload_i     (reload_i),
      .run_o        (run_o),
      .fetch_req_i  (fetch_req_i),
      .PC_i         (PC_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o),
      .addr_err_o   (addr_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge so outputs are stable.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic [15:0] pc,
                                input logic stall, input logic flush, input logic reload);
      fetch_req_i = req;
      PC_i        = pc;
      stall_i     = stall;
      flush_i     = flush;
      reload_i    = reload;
      tick();
   endtask

   task automatic loadWord(input logic [15:0] data, input logic last);
      load_valid_i = 1'b1;
      load_data_i  = data;
      load_last_i  = last;
      tick();
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
   endtask

   initial begin
      prog[0] = 16'h8800; prog[1] = 16'h8901; prog[2] = 16'h8A02;
      prog[3] = 16'h8B03; prog[4] = 16'h8C04;
      rst_n_i = 1'b0;
      load_valid_i = 1'b0; load_data_i = '0; load_last_i = 1'b0;
      reload_i = 1'b0; fetch_req_i = 1'b0; PC_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      #3;
      checkOutput("rst_ready", 32'(load_ready_o), 32'd1);
      checkOutput("rst_run",   32'(run_o),        32'd0);
      checkOutput("rst_count", 32'(load_count_o), 32'd0);
      checkOutput("rst_ovf",   32'(load_ovf_o),   32'd0);
      checkOutput("rst_inst",  32'(inst_o),       32'h0);
      checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("rst_err",   32'(addr_err_o),   32'd0);
      #9;
      rst_n_i = 1'b1;
      tick();

      // Fetch requests during LOAD must be ignored.
      fetch_req_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         loadWord(prog[i], i == 4);
         if (i == 2) begin
            checkOutput("mid_count", 32'(load_count_o), 32'd3);
            checkOutput("load_valid_ignored", 32'(inst_valid_o), 32'd0);
         end
      end
      fetch_req_i = 1'b0;
      checkOutput("load_count", 32'(load_count_o), 32'd5);
      checkOutput("run_rise",   32'(run_o),        32'd1);
      checkOutput("ready_fall", 32'(load_ready_o), 32'd0);

      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
      checkOutput("fetch_pc2", 32'(inst_o), 32'h8A02);
      checkOutput("valid_pc2", 32'(inst_valid_o), 32'd1);
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
      checkOutput("fetch_pc3", 32'(inst_o), 32'h8B03);
      checkOutput("valid_pc3", 32'(inst_valid_o), 32'd1);
      applyStimulus(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
      checkOutput("fetch_pc4", 32'(inst_o), 32'h8C04);
      checkOutput("valid_pc4", 32'(inst_valid_o), 32'd1);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_inst",  32'(inst_o),       32'h0);
      checkOutput("idle_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("ready_run",  32'(load_ready_o), 32'd0);

      applyStimulus(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("fetch_pc1", 32'(inst_o), 32'h8901);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 16'd3, 1'b1, 1'b0, 1'b0);
         checkOutput("stall_inst",  32'(inst_o),       32'h8901);
         checkOutput("stall_valid", 32'(inst_valid_o), 32'd1);
      end
      applyStimulus(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_inst",  32'(inst_o),       32'h0);
      checkOutput("flush_valid", 32'(inst_valid_o), 32'd0);

      applyStimulus(1'b1, 16'd64, 1'b0, 1'b0, 1'b0);
      checkOutput("oor_inst",  32'(inst_o),       32'h0);
      checkOutput("oor_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("oor_err",   32'(addr_err_o),   32'd1);
      applyStimulus(1'b1, 16'd63, 1'b0, 1'b0, 1'b0);
      checkOutput("pc63_err",   32'(addr_err_o),   32'd0);
      checkOutput("pc63_valid", 32'(inst_valid_o), 32'd1);
      // High bits would alias to index 2 if the compare truncated.
      applyStimulus(1'b1, 16'h1002, 1'b0, 1'b0, 1'b0);
      checkOutput("wide_err",  32'(addr_err_o), 32'd1);
      checkOutput("wide_inst", 32'(inst_o),     32'h0);

      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b1);
      checkOutput("reload_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("reload_ready", 32'(load_ready_o), 32'd1);
      checkOutput("reload_count", 32'(load_count_o), 32'd0);
      checkOutput("reload_run",   32'(run_o),        32'd0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

      load_last_i = 1'b1;
      tick();
      load_last_i = 1'b0;
      checkOutput("last_alone_ready", 32'(load_ready_o), 32'd1);
      checkOutput("last_alone_count", 32'(load_count_o), 32'd0);

      for (int i = 0; i < 65; i++) begin
         loadWord(16'h1000 + 16'(i), i == 64);
         if (i == 63) begin
            checkOutput("full_ovf", 32'(load_ovf_o), 32'd0);
         end
      end
      checkOutput("ovf_flag",  32'(load_ovf_o),   32'd1);
      checkOutput("ovf_count", 32'(load_count_o), 32'd64);
      checkOutput("ovf_run",   32'(run_o),        32'd1);
      applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_pc0",  32'(inst_o), 32'h1000);
      applyStimulus(1'b1, 16'd63, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_pc63", 32'(inst_o), 32'h103F);
      checkOutput("ovf_hold", 32'(load_ovf_o), 32'd1);

      applyStimulus(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("pre_rst_inst",  32'(inst_o),       32'h1001);
      #2;
      rst_n_i = 1'b0;
      #1;
      checkOutput("async_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("async_inst",  32'(inst_o),       32'h0);
      checkOutput("async_ready", 32'(load_ready_o), 32'd1);
      checkOutput("async_count", 32'(load_count_o), 32'd0);
      checkOutput("async_ovf",   32'(load_ovf_o),   32'd0);
      #3;
      rst_n_i = 1'b1;
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
